io_controller: RTL and testbench
================================

# io_controller

Bus-side responder for the CPU's I/O strobes. It answers port reads and writes issued by the control unit, holds the interrupt return address, and collects device interrupt lines into a pending/enable register pair. It raises `io_interrupt` and supplies the handler vector address on `d_bus`. It sits on the shared 16-bit data bus next to the register file, LU and memory, and fronts up to 14 external device ports.

## Interface
- No parameters. Port map is fixed by the 4-bit `io_addr`.
- `clk` in 1: system clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `io_read` in 1: port read request; address valid this cycle.
- `io_write` in 1: port write; data on `d_bus` this cycle.
- `io_push` in 1: drive read buffer onto `d_bus`.
- `io_addr_read` in 1: qualifies `io_addr`.
- `io_addr` in 4: port number.
- `io_store_retaddr` in 1: capture `d_bus` (pushed PC) into the return-address register.
- `io_push_retaddr` in 1: drive the return address onto `d_bus`.
- `io_push_ints` in 1: drive the pending vector onto `d_bus`.
- `io_push_int_addr` in 1: drive the handler vector address onto `d_bus` and acknowledge.
- `io_interrupt` out 1: any enabled pending interrupt.
- `d_bus` inout 16: shared data bus; high-Z unless pushing.
- `irq_in` in 16: asynchronous device interrupt lines, active high.
- `dev_rd` out 1, `dev_wr` out 1, `dev_addr` out 4, `dev_wdata` out 16: external port strobes, combinational.
- `dev_rdata` in 16: external read data, combinational response within the `dev_rd` cycle.
- `bus_conflict` out 1: sticky; set when two push strobes coincide.

## Operation
- Ports 0–13 are external. Port 14 is VEC_BASE (r/w, reset 0x0000). Port 15 is INT_EN (r/w, reset 0x0000).
- Read, cycle N (`io_read & io_addr_read`):
  - External port: `dev_rd=1`, `dev_addr=io_addr`.
  - Edge N captures `rd_buf` ← `dev_rdata`, or the internal register for ports 14/15.
- Read, cycle N+1 (`io_push`): `d_bus = rd_buf`.
- Write (`io_write & io_addr_read`):
  - External port: `dev_wr=1`, `dev_wdata=d_bus`, same cycle.
  - Port 14/15: register loads `d_bus` at the edge.
- IRQ path: each `irq_in` bit passes a 2-flop synchronizer, then a rising-edge detector, which sets `pending[i]`. Level-high does not re-trigger.
- `io_interrupt = |(pending & INT_EN)`, combinational from registers.
- `io_push_int_addr`:
  - Selected = lowest i with `pending[i] & INT_EN[i]`.
  - `d_bus = VEC_BASE + i` (16-bit wrap).
  - `pending[i]` clears at the edge.
  - If none is selected (spurious), drive `VEC_BASE + 16` and clear nothing.
- `io_push_ints`: `d_bus = pending`, no clear.
- `io_store_retaddr`: `retaddr` ← `d_bus` at the edge. `io_push_retaddr`: `d_bus = retaddr`.
- Push priority if several push strobes are active: int_addr > retaddr > ints > rd_buf. `bus_conflict` sets and is cleared only by reset.
- Simultaneous events:
  - Edge detected on the same bit being acknowledged: bit stays set (set wins).
  - Write to INT_EN in the same cycle as an ack: the ack uses the old INT_EN.

## Timing
- Reset values: `rd_buf`, `retaddr`, `pending`, sync flops, VEC_BASE and INT_EN are 0; `bus_conflict` 0. Outputs at reset: `io_interrupt` 0, `d_bus` Z, `dev_rd`/`dev_wr` 0.
- Reset asserted mid-transfer aborts it. A following `io_push` returns 0.
- Read latency: one cycle from `io_read` to valid `d_bus` during `io_push`.
- Interrupt latency: `irq_in` rising before edge E0 sets `pending` at E2. `io_interrupt` is high in the cycle after E2.
- Write data: `d_bus` is sampled at the end of the strobe cycle.
- `d_bus` drive: combinational on the push strobes, released in the cycle after.

## Structure
- Package `io_pkg`: `PORT_VEC_BASE=4'd14`, `PORT_INT_EN=4'd15`, `SPURIOUS_OFS=16'd16`, `NUM_IRQ=16`.
- Sub-module `irq_edge_sync`: 2-flop synchronizer plus rise detector, 1 bit, instantiated 16 times.
- Priority encoder stays inline.

## Test plan
- Reset: after `rst_n` low→high, `d_bus`=Z, `io_interrupt`=0, a port 15 read returns 0x0000.
- External read: `dev_rdata`=0xBEEF, `io_read` at port 3, then `io_push` → `dev_rd`/`dev_addr`=3 in cycle 1, `d_bus`=0xBEEF in cycle 2.
- Interrupt:
  - Setup: VEC_BASE=0x0100, INT_EN=0x0024, pulse `irq_in[5]` and `irq_in[2]`.
  - Expect `io_interrupt`=1 three edges later and `io_push_ints` shows 0x0024.
  - First ack gives 0x0102, second gives 0x0105, then `io_interrupt`=0.
- Spurious ack with no pending interrupt: VEC_BASE=0xFFF8 → `d_bus`=0x0008 (wrap), pending unchanged.
- Return address: `io_store_retaddr` with `d_bus`=0x1234, later `io_push_retaddr` → 0x1234.
- Conflicts:
  - `io_push_retaddr` and `io_push_ints` together → retaddr is driven, `bus_conflict`=1 sticky.
  - Edge detected in an ack cycle on the same bit → bit remains pending.

Source files
------------

// File: rtl/io_controller_pkg.sv
// Shared constants, push-source encoding and the interrupt priority helper
// for the I/O controller.
package io_pkg;

    localparam logic [3:0]  PORT_VEC_BASE = 4'd14;
    localparam logic [3:0]  PORT_INT_EN   = 4'd15;
    localparam logic [15:0] SPURIOUS_OFS  = 16'd16;
    localparam int          NUM_IRQ       = 16;

    typedef enum logic [2:0] {
        PUSH_NONE,
        PUSH_INT_ADDR,
        PUSH_RETADDR,
        PUSH_INTS,
        PUSH_RDBUF
    } push_sel_e;

    // Index of the lowest set bit; 16 when nothing is set.
    function automatic logic [4:0] lowest_set(input logic [15:0] v);
        logic [4:0] idx;
        idx = 5'd16;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) idx = 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/io_controller_if.sv
// External device port strobes: the controller is master, the device fabric
// answers reads combinationally on dev_rdata.
interface io_controller_if;
    logic        dev_rd;
    logic        dev_wr;
    logic [3:0]  dev_addr;
    logic [15:0] dev_wdata;
    logic [15:0] dev_rdata;

    modport master (output dev_rd, dev_wr, dev_addr, dev_wdata, input dev_rdata);
    modport slave  (input dev_rd, dev_wr, dev_addr, dev_wdata, output dev_rdata);
endinterface

// File: rtl/io_controller_irq_edge_sync.sv
// One interrupt line: two-flop synchronizer followed by a rising-edge detector.
module irq_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic irq_async,
    output logic rise
);
    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    always_comb begin
        s1_d = irq_async;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign rise = s2_q & ~s3_q;
endmodule

// File: rtl/io_controller.sv
// Bus-side I/O responder: port reads/writes, return-address register and a
// pending/enable interrupt pair with vectored acknowledge on the shared bus.
module io_controller
    import io_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               io_read,
    input  logic               io_write,
    input  logic               io_push,
    input  logic               io_addr_read,
    input  logic [3:0]         io_addr,
    input  logic               io_store_retaddr,
    input  logic               io_push_retaddr,
    input  logic               io_push_ints,
    input  logic               io_push_int_addr,
    output logic               io_interrupt,
    inout  wire  [15:0]        d_bus,
    input  logic [15:0]        irq_in,
    io_controller_if.master    dev,
    output logic               bus_conflict
);
    logic [15:0] rd_buf_q, rd_buf_d;
    logic [15:0] retaddr_q, retaddr_d;
    logic [15:0] pending_q, pending_d;
    logic [15:0] vec_base_q, vec_base_d;
    logic [15:0] int_en_q, int_en_d;
    logic        bus_conflict_q, bus_conflict_d;

    logic [NUM_IRQ-1:0] irq_rise;
    logic        rd_req, wr_req, ext_port;
    logic [4:0]  ack_idx;
    logic [15:0] ack_mask, int_vec, drive_val;
    logic [2:0]  push_cnt;
    push_sel_e   push_sel;

    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_irq
        irq_edge_sync u_sync (
            .clk       (clk),
            .rst_n     (rst_n),
            .irq_async (irq_in[i]),
            .rise      (irq_rise[i])
        );
    end

    always_comb begin
        rd_req   = io_read & io_addr_read;
        wr_req   = io_write & io_addr_read;
        ext_port = (io_addr != PORT_VEC_BASE) && (io_addr != PORT_INT_EN);

        rd_buf_d = rd_buf_q;
        if (rd_req) begin
            case (io_addr)
                PORT_VEC_BASE: rd_buf_d = vec_base_q;
                PORT_INT_EN:   rd_buf_d = int_en_q;
                default:       rd_buf_d = dev.dev_rdata;
            endcase
        end

        vec_base_d = vec_base_q;
        int_en_d   = int_en_q;
        if (wr_req && io_addr == PORT_VEC_BASE) vec_base_d = d_bus;
        if (wr_req && io_addr == PORT_INT_EN)   int_en_d   = d_bus;

        retaddr_d = io_store_retaddr ? d_bus : retaddr_q;

        // Acknowledge works on registered INT_EN, so a same-cycle write cannot steer it.
        ack_idx  = lowest_set(pending_q & int_en_q);
        ack_mask = '0;
        if (io_push_int_addr && !ack_idx[4]) ack_mask[ack_idx[3:0]] = 1'b1;
        int_vec  = ack_idx[4] ? (vec_base_q + SPURIOUS_OFS)
                              : (vec_base_q + {12'd0, ack_idx[3:0]});

        // A fresh edge on the bit being acknowledged must not be lost.
        pending_d = (pending_q & ~ack_mask) | irq_rise;

        push_cnt = 3'(io_push_int_addr) + 3'(io_push_retaddr)
                 + 3'(io_push_ints) + 3'(io_push);
        bus_conflict_d = bus_conflict_q | (push_cnt > 3'd1);

        if (io_push_int_addr)     push_sel = PUSH_INT_ADDR;
        else if (io_push_retaddr) push_sel = PUSH_RETADDR;
        else if (io_push_ints)    push_sel = PUSH_INTS;
        else if (io_push)         push_sel = PUSH_RDBUF;
        else                      push_sel = PUSH_NONE;

        case (push_sel)
            PUSH_INT_ADDR: drive_val = int_vec;
            PUSH_RETADDR:  drive_val = retaddr_q;
            PUSH_INTS:     drive_val = pending_q;
            PUSH_RDBUF:    drive_val = rd_buf_q;
            default:       drive_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_buf_q       <= '0;
            retaddr_q      <= '0;
            pending_q      <= '0;
            vec_base_q     <= '0;
            int_en_q       <= '0;
            bus_conflict_q <= 1'b0;
        end else begin
            rd_buf_q       <= rd_buf_d;
            retaddr_q      <= retaddr_d;
            pending_q      <= pending_d;
            vec_base_q     <= vec_base_d;
            int_en_q       <= int_en_d;
            bus_conflict_q <= bus_conflict_d;
        end
    end

    assign d_bus = (push_sel != PUSH_NONE) ? drive_val : 16'bz;

    assign dev.dev_rd    = rd_req & ext_port;
    assign dev.dev_wr    = wr_req & ext_port;
    assign dev.dev_addr  = io_addr;
    assign dev.dev_wdata = d_bus;

    assign io_interrupt = |(pending_q & int_en_q);
    assign bus_conflict = bus_conflict_q;
endmodule

// File: tb/tb_io_controller.sv
// Self-checking bench for io_controller: directed scenarios plus a randomized
// interrupt run against a cycle-level behavioural model.
module tb_io_controller;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        io_read, io_write, io_push, io_addr_read;
    logic [3:0]  io_addr;
    logic        io_store_retaddr, io_push_retaddr, io_push_ints, io_push_int_addr;
    logic        io_interrupt, bus_conflict;
    logic [15:0] irq_in;
    wire  [15:0] d_bus;
    logic        tb_drv_en;
    logic [15:0] tb_drv_val;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign d_bus = tb_drv_en ? tb_drv_val : 16'bz;

    io_controller_if dev_if ();

    io_controller dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .io_read          (io_read),
        .io_write         (io_write),
        .io_push          (io_push),
        .io_addr_read     (io_addr_read),
        .io_addr          (io_addr),
        .io_store_retaddr (io_store_retaddr),
        .io_push_retaddr  (io_push_retaddr),
        .io_push_ints     (io_push_ints),
        .io_push_int_addr (io_push_int_addr),
        .io_interrupt     (io_interrupt),
        .d_bus            (d_bus),
        .irq_in           (irq_in),
        .dev              (dev_if),
        .bus_conflict     (bus_conflict)
    );

    task automatic idle();
        io_read = 0; io_write = 0; io_push = 0; io_addr_read = 0; io_addr = 4'd0;
        io_store_retaddr = 0; io_push_retaddr = 0; io_push_ints = 0; io_push_int_addr = 0;
        tb_drv_en = 0; tb_drv_val = 16'h0000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        irq_in = 16'h0000;
        rst_n = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic wr_port(input logic [3:0] a, input logic [15:0] v);
        @(negedge clk);
        idle();
        io_write = 1; io_addr_read = 1; io_addr = a; tb_drv_en = 1; tb_drv_val = v;
        @(negedge clk);
        idle();
    endtask

    task automatic rd_port(input logic [3:0] a, output logic [15:0] v);
        @(negedge clk);
        idle();
        io_read = 1; io_addr_read = 1; io_addr = a;
        @(negedge clk);
        idle();
        io_push = 1;
        #1 v = d_bus;
        @(negedge clk);
        idle();
    endtask

    // sel bits: {int_addr, retaddr, ints, rdbuf}
    task automatic push_sample(input logic [3:0] sel, output logic [15:0] v);
        @(negedge clk);
        idle();
        io_push_int_addr = sel[3]; io_push_retaddr = sel[2];
        io_push_ints = sel[1]; io_push = sel[0];
        #1 v = d_bus;
        @(negedge clk);
        idle();
    endtask

    task automatic pulse_irq(input int bit_i);
        @(negedge clk);
        irq_in[bit_i] = 1'b1;
        @(negedge clk);
        irq_in[bit_i] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [15:0] v;
        idle();
        irq_in = 16'h0000;
        dev_if.dev_rdata = 16'h0000;
        rst_n = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        #1;
        checks++; if (io_interrupt !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", io_interrupt); end
        checks++; if (bus_conflict !== 1'b0) begin errors++; $display("FAIL reset_conflict: got %b expected 0", bus_conflict); end
        checks++; if (dev_if.dev_rd !== 1'b0 || dev_if.dev_wr !== 1'b0) begin errors++; $display("FAIL reset_strobes: got rd=%b wr=%b expected 0", dev_if.dev_rd, dev_if.dev_wr); end
        tb_drv_en = 1; tb_drv_val = 16'h0000;
        #1;
        checks++; if (d_bus !== 16'h0000) begin errors++; $display("FAIL reset_dbus_released: got %h expected 0000", d_bus); end
        idle();
        push_sample(4'b0001, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL reset_rdbuf: got %h expected 0000", v); end
        rd_port(4'd15, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL reset_int_en: got %h expected 0000", v); end
        rd_port(4'd14, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL reset_vec_base: got %h expected 0000", v); end
    endtask

    task automatic test_ext_read();
        logic [15:0] v, rdata;
        logic [3:0]  a;
        for (int k = 0; k < 8; k++) begin
            a     = (k == 0) ? 4'd3 : 4'($urandom_range(0, 13));
            rdata = (k == 0) ? 16'hBEEF : 16'($urandom);
            @(negedge clk);
            idle();
            dev_if.dev_rdata = rdata;
            io_read = 1; io_addr_read = 1; io_addr = a;
            #1;
            checks++; if (dev_if.dev_rd !== 1'b1 || dev_if.dev_addr !== a) begin errors++; $display("FAIL ext_rd_strobe: got rd=%b addr=%0d expected rd=1 addr=%0d", dev_if.dev_rd, dev_if.dev_addr, a); end
            @(negedge clk);
            idle();
            dev_if.dev_rdata = ~rdata;
            io_push = 1;
            #1 v = d_bus;
            checks++; if (v !== rdata) begin errors++; $display("FAIL ext_rd_data: got %h expected %h", v, rdata); end
            checks++; if (dev_if.dev_rd !== 1'b0) begin errors++; $display("FAIL ext_rd_release: got rd=%b expected 0", dev_if.dev_rd); end
        end
        for (int k = 0; k < 4; k++) begin
            a     = 4'($urandom_range(0, 13));
            rdata = 16'($urandom);
            @(negedge clk);
            idle();
            io_write = 1; io_addr_read = 1; io_addr = a; tb_drv_en = 1; tb_drv_val = rdata;
            #1;
            checks++; if (dev_if.dev_wr !== 1'b1 || dev_if.dev_addr !== a || dev_if.dev_wdata !== rdata) begin errors++; $display("FAIL ext_wr: got wr=%b addr=%0d data=%h expected 1 %0d %h", dev_if.dev_wr, dev_if.dev_addr, dev_if.dev_wdata, a, rdata); end
        end
        @(negedge clk);
        idle();
        io_write = 1; io_addr_read = 1; io_addr = 4'd14; tb_drv_en = 1; tb_drv_val = 16'h0000;
        #1;
        checks++; if (dev_if.dev_wr !== 1'b0) begin errors++; $display("FAIL int_port_no_dev_wr: got %b expected 0", dev_if.dev_wr); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_reset_abort();
        logic [15:0] v;
        @(negedge clk);
        idle();
        dev_if.dev_rdata = 16'hBEEF;
        io_read = 1; io_addr_read = 1; io_addr = 4'd3;
        @(negedge clk);
        idle();
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        push_sample(4'b0001, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL reset_abort: got %h expected 0000", v); end
    endtask

    task automatic test_internal_regs();
        logic [15:0] v, m_vec, m_en;
        for (int k = 0; k < 3; k++) begin
            m_vec = 16'($urandom);
            m_en  = 16'($urandom);
            wr_port(4'd14, m_vec);
            wr_port(4'd15, m_en);
            rd_port(4'd14, v);
            checks++; if (v !== m_vec) begin errors++; $display("FAIL vec_base_rw: got %h expected %h", v, m_vec); end
            rd_port(4'd15, v);
            checks++; if (v !== m_en) begin errors++; $display("FAIL int_en_rw: got %h expected %h", v, m_en); end
        end
        wr_port(4'd15, 16'h0000);
    endtask

    task automatic test_interrupt();
        logic [15:0] v;
        wr_port(4'd14, 16'h0100);
        wr_port(4'd15, 16'h0024);
        @(negedge clk);
        irq_in[5] = 1'b1; irq_in[2] = 1'b1;
        @(negedge clk);
        checks++; if (io_interrupt !== 1'b0) begin errors++; $display("FAIL irq_lat_e0: got %b expected 0", io_interrupt); end
        @(negedge clk);
        checks++; if (io_interrupt !== 1'b0) begin errors++; $display("FAIL irq_lat_e1: got %b expected 0", io_interrupt); end
        @(negedge clk);
        checks++; if (io_interrupt !== 1'b1) begin errors++; $display("FAIL irq_lat_e2: got %b expected 1", io_interrupt); end
        push_sample(4'b0010, v);
        checks++; if (v !== 16'h0024) begin errors++; $display("FAIL push_ints: got %h expected 0024", v); end
        push_sample(4'b1000, v);
        checks++; if (v !== 16'h0102) begin errors++; $display("FAIL ack_first: got %h expected 0102", v); end
        push_sample(4'b1000, v);
        checks++; if (v !== 16'h0105) begin errors++; $display("FAIL ack_second: got %h expected 0105", v); end
        repeat (3) @(negedge clk);
        checks++; if (io_interrupt !== 1'b0) begin errors++; $display("FAIL irq_level_no_retrigger: got %b expected 0", io_interrupt); end
        irq_in = 16'h0000;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_spurious();
        logic [15:0] v;
        pulse_irq(7);
        checks++; if (io_interrupt !== 1'b0) begin errors++; $display("FAIL masked_irq: got %b expected 0", io_interrupt); end
        wr_port(4'd14, 16'hFFF8);
        push_sample(4'b1000, v);
        checks++; if (v !== 16'h0008) begin errors++; $display("FAIL spurious_vec: got %h expected 0008", v); end
        push_sample(4'b0010, v);
        checks++; if (v !== 16'h0080) begin errors++; $display("FAIL spurious_no_clear: got %h expected 0080", v); end
        wr_port(4'd15, 16'h00A4);
        #1;
        checks++; if (io_interrupt !== 1'b1) begin errors++; $display("FAIL enable_pending: got %b expected 1", io_interrupt); end
        push_sample(4'b1000, v);
        checks++; if (v !== 16'hFFFF) begin errors++; $display("FAIL ack_bit7: got %h expected FFFF", v); end
        push_sample(4'b0010, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL ack_bit7_clear: got %h expected 0000", v); end
    endtask

    task automatic test_retaddr(output logic [15:0] last);
        logic [15:0] v, m;
        m = 16'h0000;
        for (int k = 0; k < 4; k++) begin
            m = (k == 0) ? 16'h1234 : 16'($urandom);
            @(negedge clk);
            idle();
            io_store_retaddr = 1; tb_drv_en = 1; tb_drv_val = m;
            @(negedge clk);
            idle();
            repeat (k) @(negedge clk);
            push_sample(4'b0100, v);
            checks++; if (v !== m) begin errors++; $display("FAIL retaddr: got %h expected %h", v, m); end
        end
        last = m;
    endtask

    task automatic test_conflict(input logic [15:0] m_ret);
        logic [15:0] v;
        checks++; if (bus_conflict !== 1'b0) begin errors++; $display("FAIL conflict_clear_before: got %b expected 0", bus_conflict); end
        push_sample(4'b0110, v);
        checks++; if (v !== m_ret) begin errors++; $display("FAIL conflict_retaddr_wins: got %h expected %h", v, m_ret); end
        checks++; if (bus_conflict !== 1'b1) begin errors++; $display("FAIL conflict_set: got %b expected 1", bus_conflict); end
        push_sample(4'b1011, v);
        checks++; if (v !== 16'h0008) begin errors++; $display("FAIL conflict_int_addr_wins: got %h expected 0008", v); end
        repeat (5) @(negedge clk);
        checks++; if (bus_conflict !== 1'b1) begin errors++; $display("FAIL conflict_sticky: got %b expected 1", bus_conflict); end
    endtask

    task automatic test_edge_in_ack();
        logic [15:0] v;
        pulse_irq(2);
        @(negedge clk);
        irq_in[2] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        idle();
        io_push_int_addr = 1;
        #1 v = d_bus;
        checks++; if (v !== 16'hFFFA) begin errors++; $display("FAIL edge_ack_vec: got %h expected FFFA", v); end
        @(negedge clk);
        idle();
        irq_in[2] = 1'b0;
        push_sample(4'b0010, v);
        checks++; if (v !== 16'h0004) begin errors++; $display("FAIL edge_in_ack_kept: got %h expected 0004", v); end
        push_sample(4'b1000, v);
        checks++; if (v !== 16'hFFFA) begin errors++; $display("FAIL edge_ack_again: got %h expected FFFA", v); end
        repeat (3) @(negedge clk);
        wr_port(4'd14, 16'h0000);
        pulse_irq(2);
        @(negedge clk);
        idle();
        io_push_int_addr = 1; io_write = 1; io_addr_read = 1; io_addr = 4'd15;
        #1 v = d_bus;
        checks++; if (v !== 16'h0002) begin errors++; $display("FAIL ack_old_int_en: got %h expected 0002", v); end
        @(negedge clk);
        idle();
        rd_port(4'd15, v);
        checks++; if (v !== 16'h0002) begin errors++; $display("FAIL int_en_loaded_in_ack: got %h expected 0002", v); end
        push_sample(4'b0010, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL ack_old_en_clear: got %h expected 0000", v); end
    endtask

    task automatic test_random_irq();
        logic [15:0] men, mvec, mpend, h1, h2, h3, ack, expv;
        int op, idx;
        do_reset();
        #1;
        checks++; if (bus_conflict !== 1'b0) begin errors++; $display("FAIL conflict_reset_clears: got %b expected 0", bus_conflict); end
        men  = 16'($urandom) | 16'h0001;
        mvec = 16'($urandom);
        wr_port(4'd14, mvec);
        wr_port(4'd15, men);
        mpend = 0; h1 = 0; h2 = 0; h3 = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            idle();
            irq_in = irq_in ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
            op = $urandom_range(0, 3);
            if (op == 1) io_push_int_addr = 1;
            if (op == 2) io_push_ints = 1;
            #1;
            checks++; if (io_interrupt !== ((mpend & men) != 0)) begin errors++; $display("FAIL rand_interrupt: got %b expected %b at iter %0d", io_interrupt, ((mpend & men) != 0), k); end
            idx = 16;
            for (int i = 15; i >= 0; i--) if (mpend[i] && men[i]) idx = i;
            expv = mvec + 16'(idx);
            ack = (op == 1 && idx < 16) ? (16'h0001 << idx) : 16'h0000;
            if (op == 1) begin
                checks++; if (d_bus !== expv) begin errors++; $display("FAIL rand_ack: got %h expected %h at iter %0d", d_bus, expv, k); end
            end
            if (op == 2) begin
                checks++; if (d_bus !== mpend) begin errors++; $display("FAIL rand_pending: got %h expected %h at iter %0d", d_bus, mpend, k); end
            end
            mpend = (mpend & ~ack) | (h2 & ~h3);
            h3 = h2; h2 = h1; h1 = irq_in;
        end
        @(negedge clk);
        idle();
        irq_in = 16'h0000;
    endtask

    initial begin
        logic [15:0] last_ret;
        test_reset();
        test_ext_read();
        test_reset_abort();
        test_internal_regs();
        test_interrupt();
        test_spurious();
        test_retaddr(last_ret);
        test_conflict(last_ret);
        test_edge_in_ack();
        test_random_irq();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
